// File: rtl/tlb_assoc_refill_pkg.sv
// Shared widths, mode encodings and FSM state type for the set-associative refill TLB.
package tlb_assoc_refill_pkg;

    localparam int unsigned MODE_WIDTH          = 2;
    localparam int unsigned VIRTUAL_ADDR_WIDTH  = 32;
    localparam int unsigned PHYSICAL_ADDR_WIDTH = 32;
    localparam int unsigned PAGE_SIZE           = 12;
    localparam int unsigned VENTRY              = VIRTUAL_ADDR_WIDTH - PAGE_SIZE;
    localparam int unsigned PENTRY              = PHYSICAL_ADDR_WIDTH - PAGE_SIZE;
    localparam int unsigned TLB_STATE_WIDTH     = 2;

    localparam logic [MODE_WIDTH-1:0] USER_MODE       = 2'd0;
    localparam logic [MODE_WIDTH-1:0] SUPERVISOR_MODE = 2'd1;

    typedef logic [VIRTUAL_ADDR_WIDTH-1:0]  vaddr_t;
    typedef logic [PHYSICAL_ADDR_WIDTH-1:0] paddr_t;
    typedef logic [VENTRY-1:0]              vpage_t;
    typedef logic [PENTRY-1:0]              ppage_t;

    typedef enum logic [TLB_STATE_WIDTH-1:0] {
        StIdle = 2'd0,
        StWalk = 2'd1,
        StFill = 2'd2
    } tlb_state_e;

    function automatic vpage_t vpage_of(input vaddr_t va);
        return va[VIRTUAL_ADDR_WIDTH-1:PAGE_SIZE];
    endfunction

endpackage

// File: rtl/tlb_assoc_refill_if.sv
// Lookup, software-write, flush and page-table-walk signals of the refill TLB.
interface tlb_assoc_refill_if;
    import tlb_assoc_refill_pkg::*;

    logic [MODE_WIDTH-1:0] mode;
    logic                  req;
    vaddr_t                vaddr;
    paddr_t                paddr;
    logic                  hit;
    logic                  stall;
    logic                  fault;
    logic                  write;
    paddr_t                paddr_new;
    logic                  flush;
    logic                  ptw_req;
    vpage_t                ptw_vpage;
    logic                  ptw_ack;
    ppage_t                ptw_ppage;
    logic                  ptw_fault;

    // Pipeline / page-table side.
    modport master (
        output mode, req, vaddr, write, paddr_new, flush, ptw_ack, ptw_ppage, ptw_fault,
        input  paddr, hit, stall, fault, ptw_req, ptw_vpage
    );

    // TLB side.
    modport slave (
        input  mode, req, vaddr, write, paddr_new, flush, ptw_ack, ptw_ppage, ptw_fault,
        output paddr, hit, stall, fault, ptw_req, ptw_vpage
    );

endinterface

// File: rtl/tlb_victim_sel.sv
// Replacement choice for one set: lowest-index invalid way, else the round-robin pointer.
module tlb_victim_sel #(
    parameter int unsigned WAYS     = 2,
    parameter int unsigned WAY_BITS = 1
) (
    input  logic [WAYS-1:0]     valid,
    input  logic [WAY_BITS-1:0] rr_ptr,
    output logic [WAY_BITS-1:0] victim,
    output logic                all_valid
);

    always_comb begin
        victim    = rr_ptr;
        all_valid = &valid;
        // Scan downwards so the lowest invalid index is the last assignment.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[w]) begin
                victim = WAY_BITS'(w);
            end
        end
    end

endmodule

// File: rtl/tlb_assoc_refill.sv
// Set-associative TLB with hardware page-table-walk refill, round-robin replacement,
// flush-all and a software write port.
module tlb_assoc_refill
    import tlb_assoc_refill_pkg::*;
#(
    parameter int unsigned WAYS     = 2,
    parameter int unsigned SET_BITS = 1
) (
    input  logic               clk,
    input  logic               reset,
    tlb_assoc_refill_if.slave  bus
);

    localparam int unsigned SETS     = 1 << SET_BITS;
    localparam int unsigned IDX_BITS = (SET_BITS > 0) ? SET_BITS : 1;
    localparam int unsigned WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic [WAYS-1:0]     valid_q [SETS];
    vpage_t              tag_q   [SETS][WAYS];
    ppage_t              ppage_q [SETS][WAYS];
    logic [WAY_BITS-1:0] rr_q    [SETS];

    tlb_state_e state_q, state_d;
    vpage_t     walk_vpage_q;
    ppage_t     fill_ppage_q;
    logic       fault_q;

    logic                user;
    vpage_t              lk_vpage;
    logic [IDX_BITS-1:0] lk_set;
    logic                lk_hit;
    ppage_t              lk_ppage;

    logic                fill_en, swr_en, wr_en;
    vpage_t              wr_vpage;
    ppage_t              wr_ppage;
    logic [IDX_BITS-1:0] wr_set;
    logic                wr_match;
    logic [WAY_BITS-1:0] wr_match_way;
    logic [WAY_BITS-1:0] victim;
    logic                all_valid;
    logic [WAY_BITS-1:0] wr_way;
    logic                rr_adv;
    logic [WAY_BITS-1:0] rr_next;

    logic start_walk, walk_ok, walk_fault;
    logic unused_offset;

    assign user          = (bus.mode != SUPERVISOR_MODE);
    assign lk_vpage      = vpage_of(bus.vaddr);
    assign unused_offset = ^bus.paddr_new[PAGE_SIZE-1:0];

    generate
        if (SET_BITS > 0) begin : g_set_idx
            assign lk_set = lk_vpage[IDX_BITS-1:0];
            assign wr_set = wr_vpage[IDX_BITS-1:0];
        end else begin : g_fully_assoc
            assign lk_set = '0;
            assign wr_set = '0;
        end
    endgenerate

    // Lookup: at most one way matches; on a miss paddr carries way 0 as a don't-care.
    always_comb begin
        lk_hit   = 1'b0;
        lk_ppage = ppage_q[lk_set][0];
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[lk_set][w] && tag_q[lk_set][w] == lk_vpage) begin
                lk_hit   = 1'b1;
                lk_ppage = ppage_q[lk_set][w];
            end
        end
    end

    always_comb begin
        if (user) begin
            bus.hit   = lk_hit;
            bus.paddr = {lk_ppage, bus.vaddr[PAGE_SIZE-1:0]};
        end else begin
            bus.hit   = 1'b1;
            bus.paddr = bus.vaddr[PHYSICAL_ADDR_WIDTH-1:0];
        end
    end

    // Flush wins over both the refill and the software write.
    always_comb begin
        fill_en  = (state_q == StFill) && !bus.flush;
        swr_en   = (state_q == StIdle) && bus.write && !bus.flush;
        wr_en    = fill_en || swr_en;
        wr_vpage = fill_en ? walk_vpage_q : lk_vpage;
        wr_ppage = fill_en ? fill_ppage_q : bus.paddr_new[PHYSICAL_ADDR_WIDTH-1:PAGE_SIZE];
    end

    always_comb begin
        wr_match     = 1'b0;
        wr_match_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[wr_set][w] && tag_q[wr_set][w] == wr_vpage) begin
                wr_match     = 1'b1;
                wr_match_way = WAY_BITS'(w);
            end
        end
    end

    tlb_victim_sel #(
        .WAYS     (WAYS),
        .WAY_BITS (WAY_BITS)
    ) u_victim_sel (
        .valid     (valid_q[wr_set]),
        .rr_ptr    (rr_q[wr_set]),
        .victim    (victim),
        .all_valid (all_valid)
    );

    // A resident page is overwritten in place; only a genuine eviction moves the pointer.
    always_comb begin
        wr_way  = wr_match ? wr_match_way : victim;
        rr_adv  = !wr_match && all_valid;
        rr_next = (rr_q[wr_set] == WAY_BITS'(WAYS - 1)) ? '0 : rr_q[wr_set] + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    tag_q[s][w]   <= '0;
                    ppage_q[s][w] <= '0;
                end
            end
        end else if (bus.flush) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
            end
        end else if (wr_en) begin
            valid_q[wr_set][wr_way] <= 1'b1;
            tag_q[wr_set][wr_way]   <= wr_vpage;
            ppage_q[wr_set][wr_way] <= wr_ppage;
            if (rr_adv) begin
                rr_q[wr_set] <= rr_next;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        start_walk = 1'b0;
        walk_ok    = 1'b0;
        walk_fault = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req && user && !lk_hit && !bus.flush && !bus.write) begin
                    start_walk = 1'b1;
                    state_d    = StWalk;
                end
            end
            // The walk runs to completion regardless of flush, mode or req changes.
            StWalk: begin
                if (bus.ptw_ack) begin
                    walk_ok    = !bus.ptw_fault;
                    walk_fault = bus.ptw_fault;
                    state_d    = bus.ptw_fault ? StIdle : StFill;
                end
            end
            StFill: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            walk_vpage_q <= '0;
            fill_ppage_q <= '0;
            fault_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= walk_fault;
            if (start_walk) begin
                walk_vpage_q <= lk_vpage;
            end
            if (walk_ok) begin
                fill_ppage_q <= bus.ptw_ppage;
            end
        end
    end

    assign bus.ptw_req   = (state_q == StWalk);
    assign bus.ptw_vpage = walk_vpage_q;
    assign bus.fault     = fault_q;
    assign bus.stall     = (state_q != StIdle) || (bus.req && user && !lk_hit);

endmodule

// File: tb/tb_tlb_assoc_refill.sv
// Directed self-checking bench for tlb_assoc_refill (WAYS=2, SET_BITS=1).
module tb_tlb_assoc_refill;
    import tlb_assoc_refill_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    tlb_assoc_refill_if bus ();

    tlb_assoc_refill #(
        .WAYS     (2),
        .SET_BITS (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Combinational lookup in user mode; never crosses a clock edge with req high.
    task automatic look(input string tag, input logic [31:0] va, input logic exp_hit,
                        input logic [31:0] exp_pa);
        bus.mode  = USER_MODE;
        bus.vaddr = va;
        bus.req   = 1'b1;
        #1;
        chk({tag, ".hit"}, 32'(bus.hit), 32'(exp_hit));
        chk({tag, ".stall"}, 32'(bus.stall), 32'(!exp_hit));
        if (exp_hit) chk({tag, ".paddr"}, bus.paddr, exp_pa);
        bus.req = 1'b0;
        #1;
    endtask

    // Full miss service: IDLE -> WALK -> FILL -> IDLE with a clean ack.
    task automatic do_walk(input string tag, input logic [31:0] va, input logic [19:0] pp);
        bus.mode  = USER_MODE;
        bus.vaddr = va;
        bus.req   = 1'b1;
        #1;
        tick();
        chk({tag, ".ptw_req"}, 32'(bus.ptw_req), 32'd1);
        bus.ptw_ack   = 1'b1;
        bus.ptw_ppage = pp;
        tick();
        bus.ptw_ack = 1'b0;
        bus.req     = 1'b0;
        tick();
    endtask

    initial begin
        reset         = 1'b1;
        bus.mode      = USER_MODE;
        bus.req       = 1'b0;
        bus.vaddr     = '0;
        bus.write     = 1'b0;
        bus.paddr_new = '0;
        bus.flush     = 1'b0;
        bus.ptw_ack   = 1'b0;
        bus.ptw_ppage = '0;
        bus.ptw_fault = 1'b0;
        tick();
        tick();
        chk("rst.ptw_req", 32'(bus.ptw_req), 32'd0);
        chk("rst.fault", 32'(bus.fault), 32'd0);
        chk("rst.stall", 32'(bus.stall), 32'd0);
        chk("rst.hit", 32'(bus.hit), 32'd0);
        reset = 1'b0;

        // First miss on 0x1234, refilled with ppage 0x5.
        bus.vaddr = 32'h0000_1234;
        bus.req   = 1'b1;
        #1;
        chk("miss.stall", 32'(bus.stall), 32'd1);
        chk("miss.hit", 32'(bus.hit), 32'd0);
        chk("miss.ptw_req_idle", 32'(bus.ptw_req), 32'd0);
        tick();
        chk("walk.ptw_req", 32'(bus.ptw_req), 32'd1);
        chk("walk.ptw_vpage", 32'(bus.ptw_vpage), 32'h1);
        chk("walk.stall", 32'(bus.stall), 32'd1);
        bus.ptw_ack   = 1'b1;
        bus.ptw_ppage = 20'h5;
        tick();
        bus.ptw_ack = 1'b0;
        #1;
        chk("fill.ptw_req", 32'(bus.ptw_req), 32'd0);
        chk("fill.stall", 32'(bus.stall), 32'd1);
        chk("fill.hit", 32'(bus.hit), 32'd0);
        tick();
        chk("replay.hit", 32'(bus.hit), 32'd1);
        chk("replay.paddr", bus.paddr, 32'h0000_5234);
        chk("replay.stall", 32'(bus.stall), 32'd0);
        bus.req = 1'b0;

        // Supervisor bypass.
        bus.mode  = SUPERVISOR_MODE;
        bus.vaddr = 32'h0000_ABCD;
        bus.req   = 1'b1;
        #1;
        chk("sup.hit", 32'(bus.hit), 32'd1);
        chk("sup.paddr", bus.paddr, 32'h0000_ABCD);
        chk("sup.stall", 32'(bus.stall), 32'd0);
        tick();
        chk("sup.ptw_req", 32'(bus.ptw_req), 32'd0);
        bus.req  = 1'b0;
        bus.mode = USER_MODE;

        // Set 0: A -> way0, B -> way1, C evicts A (rr 0->1).
        do_walk("fillA", 32'h0001_0000, 20'hA1);
        do_walk("fillB", 32'h0001_2000, 20'hB2);
        do_walk("fillC", 32'h0001_4000, 20'hC3);
        look("c_hit", 32'h0001_4567, 1'b1, 32'h000C_3567);
        look("b_hit", 32'h0001_2345, 1'b1, 32'h000B_2345);
        look("a_evicted", 32'h0001_0000, 1'b0, 32'h0);
        look("set1_kept", 32'h0000_1ABC, 1'b1, 32'h0000_5ABC);
        // Refill A evicts B (rr 1->0).
        do_walk("refillA", 32'h0001_0000, 20'hA1);
        look("b_evicted", 32'h0001_2000, 1'b0, 32'h0);
        look("a_back", 32'h0001_0010, 1'b1, 32'h000A_1010);

        // Software write to resident C overwrites in place; pointer stays at 0.
        bus.vaddr     = 32'h0001_4000;
        bus.paddr_new = 32'h0007_7000;
        bus.write     = 1'b1;
        tick();
        bus.write = 1'b0;
        look("c_rewrite", 32'h0001_4008, 1'b1, 32'h0007_7008);
        bus.vaddr     = 32'h0001_6000;
        bus.paddr_new = 32'h0006_6000;
        bus.write     = 1'b1;
        tick();
        bus.write = 1'b0;
        look("d_write", 32'h0001_6001, 1'b1, 32'h0006_6001);
        look("c_evicted_by_d", 32'h0001_4000, 1'b0, 32'h0);
        look("a_survives_d", 32'h0001_0002, 1'b1, 32'h000A_1002);

        // Faulting walk: one-cycle fault pulse, nothing written.
        bus.vaddr = 32'h0002_0000;
        bus.req   = 1'b1;
        #1;
        tick();
        bus.req       = 1'b0;
        bus.ptw_ack   = 1'b1;
        bus.ptw_fault = 1'b1;
        tick();
        bus.ptw_ack   = 1'b0;
        bus.ptw_fault = 1'b0;
        #1;
        chk("fault.pulse", 32'(bus.fault), 32'd1);
        chk("fault.ptw_req", 32'(bus.ptw_req), 32'd0);
        tick();
        chk("fault.cleared", 32'(bus.fault), 32'd0);
        look("fault.no_entry", 32'h0002_0000, 1'b0, 32'h0);

        // Flush coinciding with FILL drops the fill and clears everything.
        bus.vaddr = 32'h0003_0000;
        bus.req   = 1'b1;
        #1;
        tick();
        bus.req       = 1'b0;
        bus.ptw_ack   = 1'b1;
        bus.ptw_ppage = 20'h33;
        tick();
        bus.ptw_ack = 1'b0;
        bus.flush   = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flushfill.idle", 32'(bus.ptw_req), 32'd0);
        look("flushfill.dropped", 32'h0003_0000, 1'b0, 32'h0);
        look("flushfill.a_gone", 32'h0001_0000, 1'b0, 32'h0);
        bus.vaddr = 32'h0003_0000;
        bus.req   = 1'b1;
        #1;
        tick();
        chk("flushfill.rewalk", 32'(bus.ptw_req), 32'd1);
        bus.req       = 1'b0;
        bus.ptw_ack   = 1'b1;
        bus.ptw_ppage = 20'h33;
        tick();
        bus.ptw_ack = 1'b0;
        tick();
        look("rewalk.hit", 32'h0003_0444, 1'b1, 32'h0003_3444);

        // Flush after fills: every lookup misses.
        do_walk("fillE", 32'h0000_1234, 20'h5);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        look("flush.miss0", 32'h0003_0000, 1'b0, 32'h0);
        look("flush.miss1", 32'h0000_1234, 1'b0, 32'h0);

        // Write during WALK is ignored; reset mid-walk; late ack ignored.
        bus.vaddr = 32'h0004_0000;
        bus.req   = 1'b1;
        #1;
        tick();
        chk("rw.ptw_req", 32'(bus.ptw_req), 32'd1);
        chk("rw.ptw_vpage", 32'(bus.ptw_vpage), 32'h40);
        bus.req       = 1'b0;
        bus.vaddr     = 32'h0005_0000;
        bus.paddr_new = 32'h0009_9000;
        bus.write     = 1'b1;
        tick();
        bus.write = 1'b0;
        look("rw.write_ignored", 32'h0005_0000, 1'b0, 32'h0);
        chk("rw.still_walking", 32'(bus.ptw_req), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rw.reset_ptw_req", 32'(bus.ptw_req), 32'd0);
        chk("rw.reset_stall", 32'(bus.stall), 32'd0);
        bus.ptw_ack   = 1'b1;
        bus.ptw_ppage = 20'h44;
        tick();
        bus.ptw_ack = 1'b0;
        tick();
        chk("rw.late_ack_ptw_req", 32'(bus.ptw_req), 32'd0);
        chk("rw.late_ack_stall", 32'(bus.stall), 32'd0);
        look("rw.late_ack_no_fill", 32'h0004_0000, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
